// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder
// Brief    : Synchronises and debounces one pushbutton and classifies each
//            press by hold time into increment, decrement or clear strobes.
// Revision : 1.0
// ============================================================================
module button_event_decoder #(
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_PRESS_MS  = 1000,
    parameter int CLEAR_PRESS_MS = 3000,
    parameter int CNT_W          = 12
) (
    input  logic clk_1khz_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pressed_o,
    output logic inc_pulse_o,
    output logic dec_pulse_o,
    output logic clr_pulse_o
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_SHORT    = 3'd1;
    localparam logic [2:0] c_LONG     = 3'd2;
    localparam logic [2:0] c_CLEARED  = 3'd3;
    localparam logic [2:0] c_WAIT_REL = 3'd4;

    localparam logic [CNT_W-1:0] c_DEB_LAST  = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_PRESS_MS - 1);
    localparam logic [CNT_W-1:0] c_CLR_LAST  = CNT_W'(CLEAR_PRESS_MS - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_d;
    logic [CNT_W-1:0] r_deb_cnt;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_inc;
    logic             r_dec;
    logic             r_clr;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             w_inc_nxt;
    logic             w_dec_nxt;
    logic             w_clr_nxt;

    // Sync and debounce state resets high so a button held through reset
    // looks already-pressed and can never produce a fresh rising edge.
    always_ff @(posedge clk_1khz_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_deb     <= 1'b1;
            r_deb_d   <= 1'b1;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == c_DEB_LAST) begin
                r_deb     <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + c_CNT_ONE;
            end
        end
    end

    // Release is tested before the threshold, so a release landing on the
    // same edge as the SHORT->LONG move is seen in LONG and counts as long.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_inc_nxt   = 1'b0;
        w_dec_nxt   = 1'b0;
        w_clr_nxt   = 1'b0;
        case (r_state)
            c_WAIT_REL: begin
                if (!r_deb) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_IDLE: begin
                if (r_deb && !r_deb_d) begin
                    w_state_nxt = c_SHORT;
                    w_hold_nxt  = '0;
                end
            end
            c_SHORT: begin
                if (!r_deb) begin
                    w_inc_nxt   = 1'b1;
                    w_state_nxt = c_IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt + c_CNT_ONE;
                    if (r_hold_cnt == c_LONG_LAST) begin
                        w_state_nxt = c_LONG;
                    end
                end
            end
            c_LONG: begin
                if (!r_deb) begin
                    w_dec_nxt   = 1'b1;
                    w_state_nxt = c_IDLE;
                end else if (r_hold_cnt == c_CLR_LAST) begin
                    w_clr_nxt   = 1'b1;
                    w_state_nxt = c_CLEARED;
                end else begin
                    w_hold_nxt = r_hold_cnt + c_CNT_ONE;
                end
            end
            c_CLEARED: begin
                if (!r_deb) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_WAIT_REL;
            end
        endcase
    end

    always_ff @(posedge clk_1khz_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= c_WAIT_REL;
            r_hold_cnt <= '0;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_clr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_inc      <= w_inc_nxt;
            r_dec      <= w_dec_nxt;
            r_clr      <= w_clr_nxt;
        end
    end

    assign pressed_o   = (r_state != c_WAIT_REL) && r_deb;
    assign inc_pulse_o = r_inc;
    assign dec_pulse_o = r_dec;
    assign clr_pulse_o = r_clr;

endmodule
`default_nettype wire

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
Per-player input stage of the scoreboard, sitting directly upstream of the score counter. Runs on the 1 kHz scoreboard clock. Synchronises and debounces one raw pushbutton level, then classifies each press by hold time. Emits single-cycle increment, decrement or clear strobes that the counter consumes; one instance is used per player.

Parameters:
DEBOUNCE_MS, 20, cycles the synchronised input must differ from the debounced level before the debounced level flips
LONG_PRESS_MS, 1000, hold cycles at or above which a press is classed as long (decrement)
CLEAR_PRESS_MS, 3000, hold cycles at which a clear strobe fires while still held
CNT_W, 12, width of the debounce and hold counters; must satisfy 2^CNT_W > CLEAR_PRESS_MS

Ports:
clk_1khz_i  input  1  scoreboard clock, 1 kHz
rst_i  input  1  reset; one clock; reset is asynchronous and active-high
btn_i  input  1  raw button level, active-high (pressed = 1), asynchronous to clk
pressed_o  output  1  debounced, armed button level
inc_pulse_o  output  1  one-cycle strobe: short press released
dec_pulse_o  output  1  one-cycle strobe: long press released
clr_pulse_o  output  1  one-cycle strobe: clear hold reached

Behaviour:
- Legal parameter range: 1 <= DEBOUNCE_MS < LONG_PRESS_MS < CLEAR_PRESS_MS. Out-of-range values are not supported.
- Reset (async assert, sync release):
  - Internal sync flops, debounced level `deb` and the "was-high" state are all forced to 1.
  - Counters are 0.
  - FSM enters WAIT_REL.
  - All outputs are 0.
  - Effect: a button held through reset never produces a strobe.
- Sync: two flops on btn_i.
- Debounce:
  - deb_cnt increments each edge while sync_q != deb, and clears to 0 when they are equal.
  - When deb_cnt would reach DEBOUNCE_MS, deb <= sync_q and deb_cnt <= 0.
  - Latency: deb changes on the (DEBOUNCE_MS+2)th rising edge after the first edge that samples the new stable btn_i level.
  - Glitches shorter than DEBOUNCE_MS cycles have no effect.
- FSM states IDLE, SHORT, LONG, CLEARED, WAIT_REL:
  - WAIT_REL: pressed_o=0. Goes to IDLE when deb=0. No strobes.
  - IDLE: on deb 0->1, go to SHORT with hold_cnt <= 0.
  - SHORT: hold_cnt increments each cycle.
    - If hold_cnt reaches LONG_PRESS_MS-1 while deb=1, go to LONG.
    - If deb=0, inc_pulse_o=1 for exactly one cycle, then go to IDLE.
  - LONG: hold_cnt continues.
    - If hold_cnt reaches CLEAR_PRESS_MS-1 while deb=1, clr_pulse_o=1 for one cycle, then go to CLEARED.
    - If deb=0, dec_pulse_o=1 for one cycle, then go to IDLE.
  - CLEARED: hold_cnt frozen (saturated). On deb=0 go to IDLE with no strobe.
- Strobe timing:
  - Strobes are registered and assert on the edge following the edge where deb fell.
  - The clear strobe asserts on the edge following the threshold.
- pressed_o = deb in all states except WAIT_REL (where it is 0).
- Exactly one strobe per press at most. Strobes are mutually exclusive and never asserted on consecutive cycles from the same press.
- Threshold boundary: a release whose deb falls on the same edge that LONG is entered counts as long (decrement).
- Reset mid-press: all strobes are dropped and WAIT_REL is entered; the press in progress is discarded.

Test Plan:
- Reset released with btn_i=0:
  - pressed_o stays 0; WAIT_REL exits to IDLE after deb settles (22 cycles).
  - No strobes.
- 5-cycle glitch on btn_i from IDLE -> pressed_o stays 0 and no strobe.
- Press held 200 cycles, then released -> pressed_o rises 22 cycles after press; exactly one inc_pulse_o, one cycle wide, 23 cycles after release.
- Press held 1500 cycles -> exactly one dec_pulse_o after release; no inc or clr strobe.
- Press held 4000 cycles:
  - clr_pulse_o fires once ~3022 cycles after press.
  - No strobe on release.
  - A subsequent 100-cycle press yields one inc_pulse_o.
- Two scenarios around reset:
  - btn_i held high across rst_i assertion and release, then released -> no strobes; the next short press yields one inc_pulse_o.
  - rst_i asserted asynchronously mid-LONG -> all outputs 0 immediately.
